div_ctrl: RTL and testbench

- Sequencing controller between the EX stage and the multi-cycle radix-2 divider (`div`).
- Accepts DIV/DIVU from EX and drives the divider's start, annul and operand inputs.
- Stalls the pipeline until `ready_i` arrives, then latches the 64-bit result for HI/LO writeback.
- Aborts in-flight divides on pipeline flush and guarantees the divider is back in its free state before the next issue.

---
 rtl/div_ctrl.sv | 202 ++++++++++++++++++++
 tb/tb_div_ctrl.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/div_ctrl.sv
// Sequencer between EX and the multi-cycle radix-2 divider: issue, stall, result latch, abort and drain.
// Optional `DIV_CTRL_REUSE_EN adds a one-entry cache of the last completed divide.
module div_ctrl #(
    parameter int DRAIN_CYC   = 2,
    parameter int TIMEOUT_CYC = 40
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_div_i,
    input  logic        ex_divu_i,
    input  logic [31:0] ex_op1_i,
    input  logic [31:0] ex_op2_i,
    input  logic        flush_i,
    input  logic        stall_ext_i,
    input  logic        div_ready_i,
    input  logic [63:0] div_result_i,
    output logic        div_signed_o,
    output logic [31:0] div_op1_o,
    output logic [31:0] div_op2_o,
    output logic        div_start_o,
    output logic        div_annul_o,
    output logic        stall_o,
    output logic        hilo_we_o,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o,
    output logic        timeout_o
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE, DRAIN} state_t;

    localparam int DW = $clog2(DRAIN_CYC + 1);
    localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam logic [DW-1:0] DRAIN_LD = DW'(DRAIN_CYC);
    localparam logic [TW-1:0] TMO_LAST = TW'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);

    state_t        state_q, state_d;
    logic [DW-1:0] drain_cnt_q, drain_cnt_d;
    logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
    logic          tmo_rel_q, tmo_rel_d;
    logic          signed_q, signed_d;
    logic [31:0]   op1_q, op1_d, op2_q, op2_d;
    logic          start_q, start_d;
    logic          annul_q, annul_d;
    logic [31:0]   hi_q, hi_d, lo_q, lo_d;
    logic          timeout_q, timeout_d;
    logic          req, hit, cache_fill, cache_kill;

    assign req = (ex_div_i | ex_divu_i) & ~flush_i;

`ifdef DIV_CTRL_REUSE_EN
    // Data half of the cache lives in hi_q/lo_q: they only change on completion, as does the tag.
    logic        cvld_q, cvld_d, csgn_q, csgn_d;
    logic [31:0] cop1_q, cop1_d, cop2_q, cop2_d;

    always_comb begin
        cvld_d = cvld_q;
        csgn_d = csgn_q;
        cop1_d = cop1_q;
        cop2_d = cop2_q;
        if (cache_kill) begin
            cvld_d = 1'b0;
        end else if (cache_fill) begin
            cvld_d = 1'b1;
            csgn_d = signed_q;
            cop1_d = op1_q;
            cop2_d = op2_q;
        end
        hit = cvld_q & (csgn_q == ex_div_i) & (cop1_q == ex_op1_i) & (cop2_q == ex_op2_i);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cvld_q <= 1'b0;
            csgn_q <= 1'b0;
            cop1_q <= '0;
            cop2_q <= '0;
        end else begin
            cvld_q <= cvld_d;
            csgn_q <= csgn_d;
            cop1_q <= cop1_d;
            cop2_q <= cop2_d;
        end
    end
`else
    assign hit = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        drain_cnt_d = drain_cnt_q;
        tmo_cnt_d   = tmo_cnt_q;
        tmo_rel_d   = tmo_rel_q;
        signed_d    = signed_q;
        op1_d       = op1_q;
        op2_d       = op2_q;
        start_d     = start_q;
        annul_d     = 1'b0;
        hi_d        = hi_q;
        lo_d        = lo_q;
        timeout_d   = timeout_q;
        cache_fill  = 1'b0;
        cache_kill  = 1'b0;
        stall_o     = 1'b0;
        hilo_we_o   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (req && hit) begin
                    // Result already on hi_o/lo_o; write back now, or park in DONE under an external stall.
                    hilo_we_o = ~stall_ext_i;
                    if (stall_ext_i) state_d = DONE;
                end else if (req) begin
                    stall_o   = 1'b1;
                    signed_d  = ex_div_i;
                    op1_d     = ex_op1_i;
                    op2_d     = ex_op2_i;
                    start_d   = 1'b1;
                    tmo_cnt_d = '0;
                    state_d   = BUSY;
                end
            end
            BUSY: begin
                stall_o = 1'b1;
                if (flush_i) begin
                    annul_d     = 1'b1;
                    start_d     = 1'b0;
                    drain_cnt_d = DRAIN_LD;
                    tmo_rel_d   = 1'b0;
                    cache_kill  = 1'b1;
                    state_d     = DRAIN;
                end else if (div_ready_i) begin
                    hi_d       = div_result_i[63:32];
                    lo_d       = div_result_i[31:0];
                    cache_fill = 1'b1;
                    state_d    = DONE;
                end else if (TIMEOUT_CYC != 0 && tmo_cnt_q == TMO_LAST) begin
                    timeout_d   = 1'b1;
                    annul_d     = 1'b1;
                    start_d     = 1'b0;
                    drain_cnt_d = DRAIN_LD;
                    tmo_rel_d   = 1'b1;
                    state_d     = DRAIN;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 1'b1;
                end
            end
            DONE: begin
                hilo_we_o = ~stall_ext_i & ~flush_i;
                if (~stall_ext_i | flush_i) begin
                    start_d     = 1'b0;
                    drain_cnt_d = DRAIN_LD;
                    tmo_rel_d   = 1'b0;
                    state_d     = DRAIN;
                end
            end
            DRAIN: begin
                // After a timeout the stuck instruction is let go instead of being held here.
                stall_o     = req & ~tmo_rel_q;
                drain_cnt_d = drain_cnt_q - 1'b1;
                if (drain_cnt_q == DW'(1)) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            drain_cnt_q <= '0;
            tmo_cnt_q   <= '0;
            tmo_rel_q   <= 1'b0;
            signed_q    <= 1'b0;
            op1_q       <= '0;
            op2_q       <= '0;
            start_q     <= 1'b0;
            annul_q     <= 1'b0;
            hi_q        <= '0;
            lo_q        <= '0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            drain_cnt_q <= drain_cnt_d;
            tmo_cnt_q   <= tmo_cnt_d;
            tmo_rel_q   <= tmo_rel_d;
            signed_q    <= signed_d;
            op1_q       <= op1_d;
            op2_q       <= op2_d;
            start_q     <= start_d;
            annul_q     <= annul_d;
            hi_q        <= hi_d;
            lo_q        <= lo_d;
            timeout_q   <= timeout_d;
        end
    end

    assign div_signed_o = signed_q;
    assign div_op1_o    = op1_q;
    assign div_op2_o    = op2_q;
    assign div_start_o  = start_q;
    assign div_annul_o  = annul_q;
    assign hi_o         = hi_q;
    assign lo_o         = lo_q;
    assign timeout_o    = timeout_q;
endmodule

// File: tb/tb_div_ctrl.sv
// Directed bench for div_ctrl with a behavioural fixed-latency divider model.
module tb_div_ctrl;
    localparam int DV_LAT = 33;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ex_div_i = 1'b0, ex_divu_i = 1'b0;
    logic [31:0] ex_op1_i = '0, ex_op2_i = '0;
    logic        flush_i = 1'b0, stall_ext_i = 1'b0;
    logic        div_ready_i = 1'b0;
    logic [63:0] div_result_i = '0;
    logic        div_signed_o, div_start_o, div_annul_o, stall_o, hilo_we_o, timeout_o;
    logic [31:0] div_op1_o, div_op2_o, hi_o, lo_o;

    int checks = 0, passed = 0;
    int annul_n = 0, we_tot = 0, start_rise = 0;
    logic start_prev = 1'b0;
    bit dv_en = 1'b1;
    int dv_cnt = 0;

    div_ctrl dut (
        .clk(clk), .rst(rst), .ex_div_i(ex_div_i), .ex_divu_i(ex_divu_i),
        .ex_op1_i(ex_op1_i), .ex_op2_i(ex_op2_i), .flush_i(flush_i), .stall_ext_i(stall_ext_i),
        .div_ready_i(div_ready_i), .div_result_i(div_result_i), .div_signed_o(div_signed_o),
        .div_op1_o(div_op1_o), .div_op2_o(div_op2_o), .div_start_o(div_start_o),
        .div_annul_o(div_annul_o), .stall_o(stall_o), .hilo_we_o(hilo_we_o),
        .hi_o(hi_o), .lo_o(lo_o), .timeout_o(timeout_o)
    );

    always #5 clk = ~clk;

    // Divider model: divide-by-zero answers at once with 0/0, else after DV_LAT cycles of start.
    always @(posedge clk) begin
        if (rst || !div_start_o) begin
            dv_cnt       <= 0;
            div_ready_i  <= 1'b0;
            div_result_i <= '0;
        end else if (!div_ready_i && dv_en) begin
            if (div_op2_o == 32'd0) begin
                div_ready_i  <= 1'b1;
                div_result_i <= '0;
            end else if (dv_cnt == DV_LAT - 1) begin
                div_ready_i <= 1'b1;
                if (div_signed_o)
                    div_result_i <= {32'($signed(div_op1_o) % $signed(div_op2_o)),
                                     32'($signed(div_op1_o) / $signed(div_op2_o))};
                else
                    div_result_i <= {div_op1_o % div_op2_o, div_op1_o / div_op2_o};
            end else begin
                dv_cnt <= dv_cnt + 1;
            end
        end
    end

    always @(negedge clk) begin
        if (div_annul_o) annul_n = annul_n + 1;
        if (hilo_we_o) we_tot = we_tot + 1;
        if (div_start_o && !start_prev) start_rise = start_rise + 1;
        start_prev = div_start_o;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    // Presents one DIV/DIVU in EX until it leaves (advance or flush) and reports what was seen.
    task automatic do_op(input bit sgn, input logic [31:0] a, input logic [31:0] b,
                         input int flush_at, input int hold,
                         output int stall_n, output int we_n, output int start_low_pre,
                         output logic [31:0] hi, output logic [31:0] lo, output bit sgn_seen);
        int  c = 0;
        int  hold_left = hold;
        bit  left = 1'b0;
        bit  started = 1'b0;
        stall_n = 0; we_n = 0; start_low_pre = 0; hi = '0; lo = '0; sgn_seen = 1'b0;
        ex_div_i = sgn; ex_divu_i = !sgn; ex_op1_i = a; ex_op2_i = b;
        while (!left && c < 200) begin
            flush_i     = (c == flush_at);
            stall_ext_i = (hold_left > 0);
            @(negedge clk);
            if (stall_o) stall_n++;
            if (div_start_o) begin
                if (!started) sgn_seen = div_signed_o;
                started = 1'b1;
            end else if (!started) start_low_pre++;
            if (hilo_we_o) begin we_n++; hi = hi_o; lo = lo_o; end
            if (!stall_o && hold_left > 0) hold_left--;
            if (flush_i || (!stall_o && !stall_ext_i)) left = 1'b1;
            @(posedge clk); #1;
            c++;
        end
        checks++;
        if (!left) $display("FAIL op_leaves_ex: instruction still in EX after %0d cycles, required to leave", c);
        else passed++;
        ex_div_i = 1'b0; ex_divu_i = 1'b0; flush_i = 1'b0; stall_ext_i = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if ({div_start_o, div_annul_o, div_signed_o, timeout_o} !== 4'b0)
            $display("FAIL reset_ctl got %b required 0000", {div_start_o, div_annul_o, div_signed_o, timeout_o});
        else passed++;
        checks++;
        if ({hi_o, lo_o, div_op1_o, div_op2_o} !== 128'd0)
            $display("FAIL reset_data got %h required 0", {hi_o, lo_o, div_op1_o, div_op2_o});
        else passed++;
        checks++;
        if ({stall_o, hilo_we_o} !== 2'b00) $display("FAIL reset_comb got %b required 00", {stall_o, hilo_we_o});
        else passed++;
        @(posedge clk); #1;
        rst = 1'b0;
        idle(2);
    endtask

    task automatic test_divu();
        int s, w, sl; logic [31:0] hi, lo; bit sg;
        idle(4);
        do_op(1'b0, 32'd100, 32'd7, -1, 0, s, w, sl, hi, lo, sg);
        checks++; if (s !== 35) $display("FAIL divu_stall got %0d required 35", s); else passed++;
        checks++; if (w !== 1) $display("FAIL divu_we got %0d required 1", w); else passed++;
        checks++; if (lo !== 32'd14) $display("FAIL divu_lo got %0d required 14", lo); else passed++;
        checks++; if (hi !== 32'd2) $display("FAIL divu_hi got %0d required 2", hi); else passed++;
        checks++; if (sg !== 1'b0) $display("FAIL divu_signed got %b required 0", sg); else passed++;
        checks++; if (timeout_o !== 1'b0) $display("FAIL divu_timeout got %b required 0", timeout_o); else passed++;
    endtask

    task automatic test_signed();
        int s, w, sl; logic [31:0] hi, lo; bit sg;
        idle(4);
        do_op(1'b1, 32'hFFFF_FFF9, 32'd2, -1, 0, s, w, sl, hi, lo, sg);
        checks++; if (lo !== 32'hFFFF_FFFD) $display("FAIL sdiv_lo got %h required fffffffd", lo); else passed++;
        checks++; if (hi !== 32'hFFFF_FFFF) $display("FAIL sdiv_hi got %h required ffffffff", hi); else passed++;
        checks++; if (sg !== 1'b1) $display("FAIL sdiv_signed got %b required 1", sg); else passed++;
    endtask

    task automatic test_flush();
        int s, w, sl; logic [31:0] hi, lo; bit sg;
        int a0, w0;
        idle(4);
        a0 = annul_n; w0 = we_tot;
        do_op(1'b1, 32'd5, 32'd3, 10, 0, s, w, sl, hi, lo, sg);
        checks++; if (s !== 11) $display("FAIL flush_stall got %0d required 11", s); else passed++;
        checks++; if (w !== 0) $display("FAIL flush_we got %0d required 0", w); else passed++;
        checks++;
        if ({hi_o, lo_o} !== {32'hFFFF_FFFF, 32'hFFFF_FFFD})
            $display("FAIL flush_hilo_kept got %h required ffffffff_fffffffd", {hi_o, lo_o});
        else passed++;
        do_op(1'b0, 32'd9, 32'd4, -1, 0, s, w, sl, hi, lo, sg);
        checks++; if (sl !== 3) $display("FAIL flush_drain_start_low got %0d required 3", sl); else passed++;
        checks++; if (s !== 37) $display("FAIL flush_next_stall got %0d required 37", s); else passed++;
        checks++; if ({hi, lo} !== {32'd1, 32'd2}) $display("FAIL flush_next_hilo got %h required 1_2", {hi, lo}); else passed++;
        checks++; if (annul_n - a0 !== 1) $display("FAIL flush_annul got %0d required 1", annul_n - a0); else passed++;
        checks++; if (we_tot - w0 !== 1) $display("FAIL flush_we_total got %0d required 1", we_tot - w0); else passed++;
    endtask

    task automatic test_divzero();
        int s, w, sl; logic [31:0] hi, lo; bit sg;
        int a0;
        idle(4);
        a0 = annul_n;
        do_op(1'b0, 32'd8, 32'd0, 1, 0, s, w, sl, hi, lo, sg);
        do_op(1'b0, 32'd20, 32'd6, -1, 0, s, w, sl, hi, lo, sg);
        checks++; if (sl !== 3) $display("FAIL dz_drain_start_low got %0d required 3", sl); else passed++;
        checks++; if (s !== 37) $display("FAIL dz_next_stall got %0d required 37", s); else passed++;
        checks++; if ({hi, lo} !== {32'd2, 32'd3}) $display("FAIL dz_next_hilo got %h required 2_3", {hi, lo}); else passed++;
        checks++; if (w !== 1) $display("FAIL dz_next_we got %0d required 1", w); else passed++;
        checks++; if (annul_n - a0 !== 1) $display("FAIL dz_annul got %0d required 1", annul_n - a0); else passed++;
    endtask

    task automatic test_back_to_back();
        int s, w, sl; logic [31:0] hi, lo; bit sg;
        idle(4);
        do_op(1'b0, 32'd12, 32'd5, -1, 0, s, w, sl, hi, lo, sg);
        checks++; if ({hi, lo} !== {32'd2, 32'd2}) $display("FAIL b2b_first_hilo got %h required 2_2", {hi, lo}); else passed++;
        do_op(1'b0, 32'd30, 32'd4, -1, 0, s, w, sl, hi, lo, sg);
        checks++; if (sl !== 3) $display("FAIL b2b_start_low got %0d required 3", sl); else passed++;
        checks++; if (s !== 37) $display("FAIL b2b_stall got %0d required 37", s); else passed++;
        checks++; if ({hi, lo} !== {32'd2, 32'd7}) $display("FAIL b2b_second_hilo got %h required 2_7", {hi, lo}); else passed++;
    endtask

    task automatic test_ext_stall();
        int s, w, sl; logic [31:0] hi, lo; bit sg;
        int r0;
        idle(4);
        r0 = start_rise;
        do_op(1'b0, 32'd50, 32'd5, -1, 3, s, w, sl, hi, lo, sg);
        checks++; if (s !== 35) $display("FAIL ext_stall got %0d required 35", s); else passed++;
        checks++; if (w !== 1) $display("FAIL ext_we got %0d required 1", w); else passed++;
        checks++; if ({hi, lo} !== {32'd0, 32'd10}) $display("FAIL ext_hilo got %h required 0_10", {hi, lo}); else passed++;
        checks++; if (start_rise - r0 !== 1) $display("FAIL ext_issues got %0d required 1", start_rise - r0); else passed++;
    endtask

`ifdef DIV_CTRL_REUSE_EN
    task automatic test_reuse();
        int s, w, sl; logic [31:0] hi, lo; bit sg;
        int r0;
        idle(4);
        r0 = start_rise;
        do_op(1'b0, 32'd50, 32'd5, -1, 0, s, w, sl, hi, lo, sg);
        checks++; if (s !== 0) $display("FAIL reuse_stall got %0d required 0", s); else passed++;
        checks++; if (w !== 1) $display("FAIL reuse_we got %0d required 1", w); else passed++;
        checks++; if (lo !== 32'd10) $display("FAIL reuse_lo got %0d required 10", lo); else passed++;
        checks++; if (start_rise - r0 !== 0) $display("FAIL reuse_issues got %0d required 0", start_rise - r0); else passed++;
    endtask
`endif

    task automatic test_timeout();
        int s, w, sl; logic [31:0] hi, lo; bit sg;
        int a0;
        idle(4);
        a0 = annul_n;
        dv_en = 1'b0;
        do_op(1'b0, 32'd1, 32'd1, -1, 0, s, w, sl, hi, lo, sg);
        checks++; if (s !== 41) $display("FAIL tmo_stall got %0d required 41", s); else passed++;
        checks++; if (w !== 0) $display("FAIL tmo_we got %0d required 0", w); else passed++;
        checks++; if (timeout_o !== 1'b1) $display("FAIL tmo_flag got %b required 1", timeout_o); else passed++;
        checks++; if (annul_n - a0 !== 1) $display("FAIL tmo_annul got %0d required 1", annul_n - a0); else passed++;
        dv_en = 1'b1;
        idle(6);
        checks++; if (timeout_o !== 1'b1) $display("FAIL tmo_sticky got %b required 1", timeout_o); else passed++;
    endtask

    task automatic test_rst_mid();
        int s, w, sl; logic [31:0] hi, lo; bit sg;
        ex_divu_i = 1'b1; ex_op1_i = 32'd40; ex_op2_i = 32'd3;
        idle(5);
        rst = 1'b1; ex_divu_i = 1'b0;
        idle(1);
        @(negedge clk);
        checks++;
        if ({div_start_o, stall_o, timeout_o, div_annul_o} !== 4'b0)
            $display("FAIL rst_mid_ctl got %b required 0000", {div_start_o, stall_o, timeout_o, div_annul_o});
        else passed++;
        checks++;
        if ({hi_o, lo_o, div_op1_o} !== 96'd0) $display("FAIL rst_mid_data got %h required 0", {hi_o, lo_o, div_op1_o});
        else passed++;
        @(posedge clk); #1;
        rst = 1'b0;
        idle(3);
        do_op(1'b0, 32'd40, 32'd3, -1, 0, s, w, sl, hi, lo, sg);
        checks++; if (s !== 35) $display("FAIL rst_rec_stall got %0d required 35", s); else passed++;
        checks++; if ({hi, lo} !== {32'd1, 32'd13}) $display("FAIL rst_rec_hilo got %h required 1_13", {hi, lo}); else passed++;
    endtask

    initial begin
        idle(3);
        test_reset();
        test_divu();
        test_signed();
        test_flush();
        test_divzero();
        test_back_to_back();
        test_ext_stall();
`ifdef DIV_CTRL_REUSE_EN
        test_reuse();
`endif
        test_timeout();
        test_rst_mid();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
